// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART front end for the picorv32 native bus: TX/RX byte FIFOs
// behind DATA / STATUS / CTRL registers, with a level interrupt on pending RX data.
module uart_mmio_fifo #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int          FIFO_LOG2 = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [7:0]  tx_tdata,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  input  logic [7:0]  rx_tdata,
  input  logic        rx_tvalid,
  output logic        rx_tready,
  output logic        irq
);

  localparam int DEPTH = 1 << FIFO_LOG2;

  typedef logic [FIFO_LOG2-1:0] ptr_t;
  typedef logic [FIFO_LOG2:0]   lvl_t;

  logic [7:0] tx_mem [DEPTH];
  logic [7:0] rx_mem [DEPTH];
  ptr_t       tx_wr, tx_rd, rx_wr, rx_rd;
  lvl_t       tx_level, rx_level;
  logic       overflow;

  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        sel, is_wr, lane0;
  logic [1:0]  off;
  logic        data_wr, tx_stall, accept;
  logic        tx_push, tx_pop, rx_push, rx_pop, rx_fire, rx_drop;
  logic        ctrl_wr, flush, clr_ovf;
  logic [31:0] rdata_next;
  logic        unused_bits;

  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8]};

  assign tx_empty = (tx_level == '0);
  assign tx_full  = (tx_level == lvl_t'(DEPTH));
  assign rx_empty = (rx_level == '0);
  assign rx_full  = (rx_level == lvl_t'(DEPTH));

  assign sel   = mem_valid & ~mem_ready & (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign is_wr = |mem_wstrb;
  assign lane0 = mem_wstrb[0];
  assign off   = mem_addr[3:2];

  assign tx_tvalid = ~tx_empty;
  assign tx_tdata  = tx_mem[tx_rd];
  assign tx_pop    = tx_tvalid & tx_tready;

  // A DATA write into a full TX FIFO may still complete if the uart frees a slot this cycle.
  assign data_wr  = sel & is_wr & lane0 & (off == 2'd0);
  assign tx_stall = data_wr & tx_full & ~tx_pop;
  assign accept   = sel & ~tx_stall;
  assign tx_push  = data_wr & ~tx_stall;

  assign rx_pop  = accept & ~is_wr & (off == 2'd0) & ~rx_empty;
  assign rx_fire = rx_tvalid & rx_tready;
  assign rx_push = rx_fire & (~rx_full | rx_pop);
  assign rx_drop = rx_fire & rx_full & ~rx_pop;

  assign ctrl_wr = accept & is_wr & lane0 & (off == 2'd2);
  assign clr_ovf = ctrl_wr & mem_wdata[0];
  assign flush   = ctrl_wr & mem_wdata[1];

  always_comb begin
    rdata_next = '0;
    if (!is_wr) begin
      case (off)
        2'd0: rdata_next = rx_empty ? 32'h8000_0000 : {24'h0, rx_mem[rx_rd]};
        2'd1: rdata_next = {8'h0, 8'(tx_level), 8'(rx_level), 4'h0,
                            overflow, tx_empty, ~tx_full, ~rx_empty};
        default: rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      rx_tready <= 1'b0;
      irq       <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      mem_ready <= accept;
      mem_rdata <= accept ? rdata_next : '0;
      rx_tready <= 1'b1;
      irq       <= ~rx_empty;
      if (rx_drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_level <= '0;
    end else if (flush) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_level <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + ptr_t'(1);
      if (tx_pop)  tx_rd <= tx_rd + ptr_t'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_level <= tx_level + lvl_t'(1);
        2'b01:   tx_level <= tx_level - lvl_t'(1);
        default: tx_level <= tx_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_level <= '0;
    end else if (flush) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_level <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + ptr_t'(1);
      if (rx_pop)  rx_rd <= rx_rd + ptr_t'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_level <= rx_level + lvl_t'(1);
        2'b01:   rx_level <= rx_level - lvl_t'(1);
        default: rx_level <= rx_level;
      endcase
    end
  end

  // Storage carries no reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= mem_wdata[7:0];
    if (rx_push) rx_mem[rx_wr] <= rx_tdata;
  end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Scoreboard bench for uart_mmio_fifo: queues hold expected TX/RX bytes and
// per-scenario tasks compare DUT outputs against them.
module tb_uart_mmio_fifo;
  localparam int          DEPTH = 16;
  localparam logic [31:0] A_DATA = 32'h2000_0000;
  localparam logic [31:0] A_STAT = 32'h2000_0004;
  localparam logic [31:0] A_CTRL = 32'h2000_0008;
  localparam logic [31:0] A_RSV  = 32'h2000_000C;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [7:0]  tx_tdata, rx_tdata;
  logic        tx_tvalid, tx_tready, rx_tvalid, rx_tready, irq;

  int tests_run = 0;
  int failed = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit model_ovf = 1'b0;

  uart_mmio_fifo #(.BASE_ADDR(32'h2000_0000), .FIFO_LOG2(4)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_status(input int txl);
    int rxl;
    rxl = rxq.size();
    return {8'h0, 8'(txl), 8'(rxl), 4'h0, model_ovf, (txl == 0), (txl < DEPTH), (rxl != 0)};
  endfunction

  // All bus/stream tasks start and end at posedge+1.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input int lim, output bit got);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = 4'hf; got = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      if (mem_ready) begin got = 1'b1; break; end
    end
    mem_valid = 1'b0; mem_wstrb = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output bit got);
    mem_valid = 1'b1; mem_addr = a; mem_wstrb = 4'h0; got = 1'b0; d = 'x;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (mem_ready) begin got = 1'b1; d = mem_rdata; break; end
    end
    mem_valid = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b);
    rx_tvalid = 1'b1; rx_tdata = b;
    @(posedge clk); #1;
    rx_tvalid = 1'b0;
    if (rxq.size() < DEPTH) rxq.push_back(b);
    else model_ovf = 1'b1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    tx_tready = 1'b0; rx_tvalid = 1'b0; rx_tdata = '0;
    #1;
    tests_run++;
    if ({mem_ready, tx_tvalid, rx_tready, irq} !== 4'b0 || mem_rdata !== 32'h0) begin
      failed++;
      $display("FAIL reset_outputs got rdy=%b tv=%b rr=%b irq=%b rdata=%h exp all 0",
               mem_ready, tx_tvalid, rx_tready, irq, mem_rdata);
    end
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (rx_tready !== 1'b1) begin failed++; $display("FAIL rx_tready_after_reset got %b exp 1", rx_tready); end
  endtask

  task automatic test_tx_order;
    logic [31:0] d; bit got; int seen;
    tx_tready = 1'b1; seen = 0;
    fork
      begin
        logic [7:0] bytes [3] = '{8'h41, 8'h42, 8'h43};
        for (int k = 0; k < 3; k++) begin
          bit g;
          txq.push_back(bytes[k]);
          bus_write(A_DATA, {24'hABCDEF, bytes[k]}, 10, g);
          tests_run++;
          if (!g) begin failed++; $display("FAIL t1_write_ack byte %h got no ready exp ready", bytes[k]); end
        end
      end
      begin
        for (int i = 0; i < 60 && seen < 3; i++) begin
          @(negedge clk);
          if (tx_tvalid && tx_tready) begin
            tests_run++;
            if (txq.size() == 0) begin
              failed++; $display("FAIL t1_tx_spurious got %h exp no byte", tx_tdata);
            end else begin
              logic [7:0] e;
              e = txq.pop_front();
              if (tx_tdata !== e) begin failed++; $display("FAIL t1_tx_order got %h exp %h", tx_tdata, e); end
            end
            seen++;
          end
        end
      end
    join
    @(posedge clk); #1;
    tests_run++;
    if (seen != 3) begin failed++; $display("FAIL t1_tx_count got %0d exp 3", seen); end
    bus_read(A_STAT, d, got);
    tests_run++;
    if (!got || d !== exp_status(0) || d[2] !== 1'b1) begin
      failed++; $display("FAIL t1_status got %h exp %h", d, exp_status(0));
    end
    tx_tready = 1'b0;
  endtask

  task automatic test_tx_full;
    logic [31:0] d; bit got; int seen;
    tx_tready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      txq.push_back(8'(8'h80 + k));
      bus_write(A_DATA, 32'(8'h80 + k), 10, got);
      tests_run++;
      if (!got) begin failed++; $display("FAIL t2_write_ack idx %0d got no ready exp ready", k); end
    end
    bus_read(A_STAT, d, got);
    tests_run++;
    if (!got || d[23:16] !== 8'd16 || d !== exp_status(DEPTH)) begin
      failed++; $display("FAIL t2_status_full got %h exp %h", d, exp_status(DEPTH));
    end
    mem_valid = 1'b1; mem_addr = A_DATA; mem_wdata = 32'h99; mem_wstrb = 4'hf;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (mem_ready !== 1'b0) begin failed++; $display("FAIL t2_stall cycle %0d got ready=%b exp 0", i, mem_ready); end
    end
    tests_run++;
    if (tx_tdata !== txq[0]) begin failed++; $display("FAIL t2_head_stable got %h exp %h", tx_tdata, txq[0]); end
    tx_tready = 1'b1;
    @(posedge clk); #1;
    tx_tready = 1'b0;
    void'(txq.pop_front());
    tests_run++;
    if (mem_ready !== 1'b1) begin failed++; $display("FAIL t2_ready_after_pop got %b exp 1", mem_ready); end
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    txq.push_back(8'h99);
    tx_tready = 1'b1; seen = 0;
    for (int i = 0; i < 60 && seen < DEPTH; i++) begin
      @(negedge clk);
      if (tx_tvalid) begin
        logic [7:0] e;
        e = (txq.size() != 0) ? txq.pop_front() : 8'hxx;
        tests_run++;
        if (tx_tdata !== e) begin failed++; $display("FAIL t2_drain got %h exp %h", tx_tdata, e); end
        seen++;
      end
    end
    @(posedge clk); #1;
    tx_tready = 1'b0;
    tests_run++;
    if (seen != DEPTH || tx_tvalid !== 1'b0) begin
      failed++; $display("FAIL t2_drain_count got %0d tvalid=%b exp %0d tvalid=0", seen, tx_tvalid, DEPTH);
    end
  endtask

  task automatic test_rx_overflow;
    logic [31:0] d; bit got;
    for (int k = 0; k < DEPTH; k++) rx_send(8'(8'h10 + k));
    rx_send(8'h20);
    @(posedge clk); #1;
    tests_run++;
    if (irq !== 1'b1) begin failed++; $display("FAIL t3_irq got %b exp 1", irq); end
    bus_read(A_STAT, d, got);
    tests_run++;
    if (!got || d !== exp_status(0)) begin failed++; $display("FAIL t3_status got %h exp %h", d, exp_status(0)); end
    for (int k = 0; k < DEPTH; k++) begin
      logic [7:0] e;
      e = rxq.pop_front();
      bus_read(A_DATA, d, got);
      tests_run++;
      if (!got || d !== {24'h0, e}) begin failed++; $display("FAIL t3_rx_read got %h exp %h", d, {24'h0, e}); end
    end
    bus_read(A_DATA, d, got);
    tests_run++;
    if (!got || d !== 32'h8000_0000) begin failed++; $display("FAIL t3_rx_empty_read got %h exp 80000000", d); end
    tests_run++;
    if (irq !== 1'b0) begin failed++; $display("FAIL t3_irq_clear got %b exp 0", irq); end
  endtask

  task automatic test_rx_simul;
    logic [31:0] d; bit got; logic [7:0] e;
    bus_write(A_CTRL, 32'h1, 10, got);
    model_ovf = 1'b0;
    bus_read(A_STAT, d, got);
    tests_run++;
    if (!got || d !== exp_status(0)) begin failed++; $display("FAIL t4_ovf_clear got %h exp %h", d, exp_status(0)); end
    for (int k = 0; k < DEPTH; k++) rx_send(8'(8'h60 + k));
    mem_valid = 1'b1; mem_addr = A_DATA; mem_wstrb = 4'h0;
    rx_tvalid = 1'b1; rx_tdata = 8'h55;
    @(posedge clk); #1;
    rx_tvalid = 1'b0;
    e = rxq.pop_front();
    rxq.push_back(8'h55);
    tests_run++;
    if (mem_ready !== 1'b1 || mem_rdata !== {24'h0, e}) begin
      failed++; $display("FAIL t4_simul_read got rdy=%b %h exp rdy=1 %h", mem_ready, mem_rdata, {24'h0, e});
    end
    mem_valid = 1'b0;
    @(posedge clk); #1;
    bus_read(A_STAT, d, got);
    tests_run++;
    if (!got || d !== exp_status(0)) begin failed++; $display("FAIL t4_status got %h exp %h", d, exp_status(0)); end
    for (int k = 0; k < DEPTH; k++) begin
      e = rxq.pop_front();
      bus_read(A_DATA, d, got);
      tests_run++;
      if (!got || d !== {24'h0, e}) begin failed++; $display("FAIL t4_rx_read got %h exp %h", d, {24'h0, e}); end
    end
  endtask

  task automatic test_flush;
    logic [31:0] d; bit got;
    tx_tready = 1'b0;
    for (int k = 0; k < 3; k++) bus_write(A_DATA, 32'(8'hC0 + k), 10, got);
    for (int k = 0; k < DEPTH + 1; k++) rx_send(8'(8'hA0 + k));
    for (int k = 0; k < DEPTH - 3; k++) begin
      void'(rxq.pop_front());
      bus_read(A_DATA, d, got);
    end
    bus_read(A_STAT, d, got);
    tests_run++;
    if (!got || d !== exp_status(3) || tx_tvalid !== 1'b1 || irq !== 1'b1) begin
      failed++; $display("FAIL t5_pre got %h tv=%b irq=%b exp %h tv=1 irq=1", d, tx_tvalid, irq, exp_status(3));
    end
    bus_write(A_CTRL, 32'h3, 10, got);
    rxq.delete(); model_ovf = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (tx_tvalid !== 1'b0 || irq !== 1'b0) begin
      failed++; $display("FAIL t5_flush_outputs got tv=%b irq=%b exp 0 0", tx_tvalid, irq);
    end
    bus_read(A_STAT, d, got);
    tests_run++;
    if (!got || d !== exp_status(0)) begin failed++; $display("FAIL t5_status got %h exp %h", d, exp_status(0)); end
  endtask

  task automatic test_misc;
    logic [31:0] d; bit got;
    bus_read(A_CTRL, d, got);
    tests_run++;
    if (!got || d !== 32'h0) begin failed++; $display("FAIL ctrl_read got %h exp 0", d); end
    bus_read(A_RSV, d, got);
    tests_run++;
    if (!got || d !== 32'h0) begin failed++; $display("FAIL rsv_read got %h exp 0", d); end
    bus_write(A_STAT, 32'hFFFF_FFFF, 10, got);
    tests_run++;
    if (!got) begin failed++; $display("FAIL status_write_ack got no ready exp ready"); end
    bus_write(A_RSV, 32'hFF, 10, got);
    tests_run++;
    if (!got) begin failed++; $display("FAIL rsv_write_ack got no ready exp ready"); end
    bus_write(32'h2000_0010, 32'h77, 5, got);
    tests_run++;
    if (got || tx_tvalid !== 1'b0) begin
      failed++; $display("FAIL unselected got ready=%b tv=%b exp 0 0", got, tx_tvalid);
    end
    bus_read(A_STAT, d, got);
    tests_run++;
    if (!got || d !== exp_status(0)) begin failed++; $display("FAIL misc_status got %h exp %h", d, exp_status(0)); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d; bit got; bit seen_rdy;
    tx_tready = 1'b0;
    rx_send(8'h11);
    rx_send(8'h22);
    for (int k = 0; k < DEPTH; k++) bus_write(A_DATA, 32'(k), 10, got);
    mem_valid = 1'b1; mem_addr = A_DATA; mem_wdata = 32'hEE; mem_wstrb = 4'hf;
    repeat (2) begin @(posedge clk); #1; end
    tests_run++;
    if (mem_ready !== 1'b0 || irq !== 1'b1 || tx_tvalid !== 1'b1) begin
      failed++; $display("FAIL t6_pre got rdy=%b irq=%b tv=%b exp 0 1 1", mem_ready, irq, tx_tvalid);
    end
    #2 resetn = 1'b0;
    #1;
    tests_run++;
    if ({mem_ready, tx_tvalid, rx_tready, irq} !== 4'b0 || mem_rdata !== 32'h0) begin
      failed++;
      $display("FAIL t6_async_reset got rdy=%b tv=%b rr=%b irq=%b rdata=%h exp all 0",
               mem_ready, tx_tvalid, rx_tready, irq, mem_rdata);
    end
    txq.delete(); rxq.delete(); model_ovf = 1'b0;
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    #2 resetn = 1'b1;
    seen_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (mem_ready) seen_rdy = 1'b1;
    end
    tests_run++;
    if (seen_rdy) begin failed++; $display("FAIL t6_no_ready got ready pulse exp none"); end
    bus_read(A_STAT, d, got);
    tests_run++;
    if (!got || d !== exp_status(0)) begin failed++; $display("FAIL t6_status got %h exp %h", d, exp_status(0)); end
  endtask

  initial begin
    test_reset();
    test_tx_order();
    test_tx_full();
    test_rx_overflow();
    test_rx_simul();
    test_flush();
    test_misc();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout got no finish exp finish");
    $fatal(1);
  end

endmodule
